// File: rtl/sp_xbus_bridge_if.sv
// Bus bundle for sp_xbus_bridge: SP byte-port Wishbone signals and the
// 16-bit big-endian memory port, with master/slave modports.
// Ports (signals):
//   wb_adr_i[MEM_AW:0]  byte address, bit 0 = byte lane (0 = high byte)
//   wb_dat_i/wb_dat_o   8-bit write/read data
//   wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_ack_o
//   mem_req_o, mem_we_o, mem_adr_o[MEM_AW-1:0]
//   mem_sel_o[1:0]      bit 1 = high byte lane
//   mem_dat_o/mem_dat_i 16-bit words, [15:8] = high byte
//   mem_ack_i           completion pulse
// master: the SP and memory environment; slave: the bridge itself.
interface sp_xbus_bridge_if #(
    parameter int MEM_AW = 23
);
    logic [MEM_AW:0]   wb_adr_i;
    logic [7:0]        wb_dat_i;
    logic [7:0]        wb_dat_o;
    logic              wb_we_i;
    logic              wb_sel_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic              wb_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [MEM_AW-1:0] mem_adr_o;
    logic [1:0]        mem_sel_o;
    logic [15:0]       mem_dat_o;
    logic [15:0]       mem_dat_i;
    logic              mem_ack_i;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i,
        output wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o,
        input  mem_req_o, mem_we_o, mem_adr_o,
        input  mem_sel_o, mem_dat_o,
        output mem_dat_i, mem_ack_i
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i,
        input  wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o,
        output mem_req_o, mem_we_o, mem_adr_o,
        output mem_sel_o, mem_dat_o,
        input  mem_dat_i, mem_ack_i
    );
endinterface

// File: rtl/sp_xbus_bridge.sv
// SP byte-serial Wishbone slave bridged onto the 16-bit big-endian memory
// port, with a one-word read latch and a one-word write-combining buffer.
// Ports: clk, reset_n (async active-low), bus (sp_xbus_bridge_if.slave),
//   invalidate_i (drop read latch), timeout_o (sticky watchdog flag).
// Bit order: wb_adr_i[0] is the byte lane, mem lane/byte [1]/[15:8] = high.
// Optional: define SP_XBUS_BRIDGE_TIMEOUT_EN for the memory watchdog.
module sp_xbus_bridge #(
    parameter int MEM_AW         = 23,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic            clk,
    input  logic            reset_n,
    sp_xbus_bridge_if.slave bus,
    input  logic            invalidate_i,
    output logic            timeout_o
);
    typedef enum logic [1:0] {
        S_IDLE, S_FETCH, S_FLUSH, S_ACK
    } state_t;

    state_t r_state, w_state_nx;
    state_t r_next, w_next_nx;

    logic              r_rl_valid;
    logic [MEM_AW-1:0] r_rl_adr;
    logic [15:0]       r_rl_data;
    logic [1:0]        r_lanes;
    logic [MEM_AW-1:0] r_wadr;
    logic [15:0]       r_wdat;
    logic              r_flush_pend;
    logic [MEM_AW-1:0] r_fadr;
    logic              r_lane;
    logic [7:0]        r_dat;

    logic [MEM_AW-1:0] w_adr;
    logic              w_lane;
    logic              w_req;
    logic [1:0]        w_lbit;
    logic [1:0]        w_lanes_m;
    logic              w_rl_ok;
    logic              w_wb_same;
    logic              w_hit;
    logic              w_wfits;
    logic              w_busy;
    logic              w_done;
    logic              w_tmo;
    logic              w_do_hit;
    logic              w_do_merge;
    logic              w_do_cap;

    assign w_adr     = bus.wb_adr_i[MEM_AW:1];
    assign w_lane    = bus.wb_adr_i[0];
    assign w_req     = bus.wb_cyc_i & bus.wb_stb_i;
    assign w_lbit    = w_lane ? 2'b01 : 2'b10;
    assign w_lanes_m = r_lanes | w_lbit;
    // An invalidate in the same cycle already counts as a miss.
    assign w_rl_ok   = r_rl_valid & ~invalidate_i & (r_rl_adr == w_adr);
    assign w_wb_same = (r_lanes != 2'b00) & (r_wadr == w_adr);
    assign w_hit     = w_rl_ok & ~w_wb_same;
    assign w_wfits   = (r_lanes == 2'b00) | (r_wadr == w_adr);
    assign w_busy    = (r_state == S_FETCH) | (r_state == S_FLUSH);
    assign w_done    = bus.mem_ack_i | w_tmo;

`ifdef SP_XBUS_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_tmo;

    assign w_tmo = w_busy & ~bus.mem_ack_i &
                   (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = r_tmo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
            r_tmo  <= 1'b0;
        end else if (w_busy & ~w_done) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
            if (w_tmo) r_tmo <= 1'b1;
        end
    end
`else
    assign w_tmo     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_next  <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
            r_next  <= w_next_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_next_nx  = r_next;
        w_do_hit   = 1'b0;
        w_do_merge = 1'b0;
        w_do_cap   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (!bus.wb_we_i) begin
                        if (w_hit) begin
                            w_state_nx = S_ACK;
                            w_do_hit   = 1'b1;
                        end else begin
                            w_do_cap = 1'b1;
                            if (r_lanes != 2'b00) begin
                                w_state_nx = S_FLUSH;
                                w_next_nx  = S_FETCH;
                            end else begin
                                w_state_nx = S_FETCH;
                            end
                        end
                    end else if (!bus.wb_sel_i) begin
                        w_state_nx = S_ACK;
                    end else if (w_wfits) begin
                        w_state_nx = S_ACK;
                        w_do_merge = 1'b1;
                    end else begin
                        // Evict the other word; request retried in IDLE.
                        w_state_nx = S_FLUSH;
                        w_next_nx  = S_IDLE;
                    end
                end else if (!bus.wb_cyc_i && r_lanes != 2'b00) begin
                    w_state_nx = S_FLUSH;
                    w_next_nx  = S_IDLE;
                end
            end
            S_FETCH: begin
                if (w_done)
                    w_state_nx = bus.wb_cyc_i ? S_ACK : S_IDLE;
            end
            S_FLUSH: begin
                if (w_done)
                    w_state_nx = (r_next == S_FETCH && bus.wb_cyc_i)
                               ? S_FETCH : S_IDLE;
            end
            S_ACK: begin
                if (r_flush_pend) begin
                    w_state_nx = S_FLUSH;
                    w_next_nx  = S_IDLE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rl_valid   <= 1'b0;
            r_rl_adr     <= '0;
            r_rl_data    <= '0;
            r_lanes      <= 2'b00;
            r_wadr       <= '0;
            r_wdat       <= '0;
            r_flush_pend <= 1'b0;
            r_fadr       <= '0;
            r_lane       <= 1'b0;
            r_dat        <= '0;
        end else begin
            if (w_do_cap) begin
                r_fadr <= w_adr;
                r_lane <= w_lane;
            end
            if (w_do_hit)
                r_dat <= w_lane ? r_rl_data[7:0] : r_rl_data[15:8];
            if (w_do_merge) begin
                r_wadr       <= w_adr;
                r_lanes      <= w_lanes_m;
                r_flush_pend <= (w_lanes_m == 2'b11);
                if (w_lane) r_wdat[7:0]  <= bus.wb_dat_i;
                else        r_wdat[15:8] <= bus.wb_dat_i;
                // Keep the latch coherent with our own writes.
                if (r_rl_adr == w_adr) begin
                    if (w_lane) r_rl_data[7:0]  <= bus.wb_dat_i;
                    else        r_rl_data[15:8] <= bus.wb_dat_i;
                end
            end
            if (r_state == S_ACK)
                r_flush_pend <= 1'b0;
            if (r_state == S_FLUSH && w_done)
                r_lanes <= 2'b00;
            if (r_state == S_FETCH && w_done) begin
                if (bus.mem_ack_i) begin
                    r_rl_adr   <= r_fadr;
                    r_rl_data  <= bus.mem_dat_i;
                    r_rl_valid <= 1'b1;
                    r_dat      <= r_lane ? bus.mem_dat_i[7:0]
                                         : bus.mem_dat_i[15:8];
                end else begin
                    r_rl_valid <= 1'b0;
                    r_dat      <= 8'hFF;
                end
            end
            if (invalidate_i)
                r_rl_valid <= 1'b0;
        end
    end

    always_comb begin
        bus.wb_ack_o  = 1'b0;
        bus.wb_dat_o  = '0;
        bus.mem_req_o = 1'b0;
        bus.mem_we_o  = 1'b0;
        bus.mem_adr_o = '0;
        bus.mem_sel_o = 2'b00;
        bus.mem_dat_o = '0;
        unique case (r_state)
            S_FETCH: begin
                bus.mem_req_o = 1'b1;
                bus.mem_adr_o = r_fadr;
                bus.mem_sel_o = 2'b11;
            end
            S_FLUSH: begin
                bus.mem_req_o = 1'b1;
                bus.mem_we_o  = 1'b1;
                bus.mem_adr_o = r_wadr;
                bus.mem_sel_o = r_lanes;
                bus.mem_dat_o = r_wdat;
            end
            S_ACK: begin
                bus.wb_ack_o = 1'b1;
                bus.wb_dat_o = r_dat;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sp_xbus_bridge.sv
// Scoreboard bench for sp_xbus_bridge: directed SP byte accesses with a
// 3-cycle memory model; Wishbone and memory monitors pop expectations.
module tb_sp_xbus_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inv = 1'b0;
    logic tmo;
    logic mem_hold = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int mack_cyc = -10;

    sp_xbus_bridge_if #(.MEM_AW(23)) bus ();

    sp_xbus_bridge #(.MEM_AW(23), .TIMEOUT_CYCLES(1023)) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .bus          (bus.slave),
        .invalidate_i (inv),
        .timeout_o    (tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic       we;
        logic [7:0] d;
        int         lat;
        int         start;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [22:0] adr;
        logic [1:0]  sel;
        logic [15:0] d;
    } mem_exp_t;

    wb_exp_t  wq[$];
    mem_exp_t mq[$];
    logic [15:0] mem [0:1023];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic we, input logic [22:0] adr,
                           input logic [1:0] sel, input logic [15:0] d);
        mem_exp_t m;
        m.we = we; m.adr = adr; m.sel = sel; m.d = d;
        mq.push_back(m);
    endtask

    // lat: >0 fixed strobe-to-ack cycles, 0 = cycle after mem ack, <0 none
    task automatic wb_go(input logic we, input logic [23:0] adr,
                         input logic [7:0] d, input logic sel,
                         input logic [7:0] exp, input int lat);
        wb_exp_t e;
        int n;
        e.we = we; e.d = exp; e.lat = lat; e.start = cyc_cnt;
        wq.push_back(e);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = d;
        bus.wb_sel_i = sel;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.wb_ack_o) break;
        end
        if (n == 300) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: adr %h got no ack, required ack", adr);
        end
        @(posedge clk);
        #1;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic rd(input logic [23:0] adr, input logic [7:0] exp,
                      input int lat);
        wb_go(1'b0, adr, 8'h00, 1'b1, exp, lat);
    endtask

    task automatic wr(input logic [23:0] adr, input logic [7:0] d,
                      input logic sel, input int lat);
        wb_go(1'b1, adr, d, sel, 8'h00, lat);
    endtask

    task automatic end_cycle();
        bus.wb_cyc_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : wb_mon
        wb_exp_t e;
        if (bus.wb_ack_o) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack, required none");
            end else begin
                e = wq.pop_front();
                if (!e.we)
                    chk("rd_data", 32'(bus.wb_dat_o), 32'(e.d));
                if (e.lat > 0)
                    chk("ack_latency", 32'(cyc_cnt - e.start + 1),
                        32'(e.lat));
                else if (e.lat == 0)
                    chk("ack_after_mem_ack", 32'(cyc_cnt),
                        32'(mack_cyc + 1));
            end
        end
    end

    initial begin : mem_model
        int m_cnt;
        logic [40:0] snap;
        logic [15:0] mask;
        mem_exp_t me;
        m_cnt = 0;
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
                m_cnt = 0;
            end else if (bus.mem_req_o && !mem_hold) begin
                m_cnt++;
                if (m_cnt == 1)
                    snap = {bus.mem_we_o, bus.mem_adr_o,
                            bus.mem_sel_o, bus.mem_dat_o};
                if (m_cnt == 3) begin
                    chk("mem_stable", 32'(snap ^ {bus.mem_we_o,
                        bus.mem_adr_o, bus.mem_sel_o, bus.mem_dat_o}), 0);
                    mask = {{8{bus.mem_sel_o[1]}}, {8{bus.mem_sel_o[0]}}};
                    if (mq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: we %b adr %h, required none",
                                 bus.mem_we_o, bus.mem_adr_o);
                    end else begin
                        me = mq.pop_front();
                        chk("mem_we", 32'(bus.mem_we_o), 32'(me.we));
                        chk("mem_adr", 32'(bus.mem_adr_o), 32'(me.adr));
                        chk("mem_sel", 32'(bus.mem_sel_o), 32'(me.sel));
                        if (me.we)
                            chk("mem_wdata", 32'(bus.mem_dat_o & mask),
                                32'(me.d & mask));
                    end
                    if (bus.mem_we_o)
                        mem[bus.mem_adr_o[9:0]] =
                            (mem[bus.mem_adr_o[9:0]] & ~mask) |
                            (bus.mem_dat_o & mask);
                    else
                        bus.mem_dat_i = mem[bus.mem_adr_o[9:0]];
                    bus.mem_ack_i = 1'b1;
                    mack_cyc = cyc_cnt;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    initial begin : stim
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h080] = 16'h1234;
        mem[10'h081] = 16'h5678;
        mem[10'h200] = 16'h9ABC;
        mem[10'h000] = 16'hBEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.wb_ack_o), 0);
        chk("rst_dat", 32'(bus.wb_dat_o), 0);
        chk("rst_req", 32'(bus.mem_req_o), 0);
        chk("rst_we", 32'(bus.mem_we_o), 0);
        chk("rst_adr", 32'(bus.mem_adr_o), 0);
        chk("rst_sel", 32'(bus.mem_sel_o), 0);
        chk("rst_mdat", 32'(bus.mem_dat_o), 0);
        chk("rst_tmo", 32'(tmo), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four byte reads: two fetches, two latch hits
        exp_mem(1'b0, 23'h000080, 2'b11, 16'h0);
        rd(24'h000100, 8'h12, 0);
        rd(24'h000101, 8'h34, 2);
        exp_mem(1'b0, 23'h000081, 2'b11, 16'h0);
        rd(24'h000102, 8'h56, 0);
        rd(24'h000103, 8'h78, 2);
        end_cycle();

        // Write combining into two full-word writes
        exp_mem(1'b1, 23'h000100, 2'b11, 16'hAABB);
        exp_mem(1'b1, 23'h000101, 2'b11, 16'hCCDD);
        wr(24'h000200, 8'hAA, 1'b1, 2);
        wr(24'h000201, 8'hBB, 1'b1, 2);
        wr(24'h000202, 8'hCC, 1'b1, -1);
        wr(24'h000203, 8'hDD, 1'b1, 2);
        end_cycle();

        // Lone low byte flushed by end of cycle
        exp_mem(1'b1, 23'h000180, 2'b01, 16'h0055);
        wr(24'h000301, 8'h55, 1'b1, 2);
        end_cycle();

        // Invalidate forces a refetch
        exp_mem(1'b0, 23'h000200, 2'b11, 16'h0);
        rd(24'h000400, 8'h9A, 0);
        inv = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
        exp_mem(1'b0, 23'h000200, 2'b11, 16'h0);
        rd(24'h000401, 8'hBC, 0);
        end_cycle();

        // Reset in the middle of a fetch
        mem_hold = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 1'b1;
        bus.wb_adr_i = 24'h000000;
        repeat (4) @(posedge clk);
        #1;
        chk("fetch_req_held", 32'(bus.mem_req_o), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bus.mem_req_o), 0);
        chk("rst_mid_adr", 32'(bus.mem_adr_o), 0);
        chk("rst_mid_sel", 32'(bus.mem_sel_o), 0);
        chk("rst_mid_ack", 32'(bus.wb_ack_o), 0);
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        mem_hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_mem(1'b0, 23'h000200, 2'b11, 16'h0);
        rd(24'h000400, 8'h9A, 0);
        exp_mem(1'b0, 23'h000000, 2'b11, 16'h0);
        rd(24'h000000, 8'hBE, 0);
        end_cycle();

        // Write to a different word evicts the buffer
        exp_mem(1'b1, 23'h000300, 2'b10, 16'h1100);
        exp_mem(1'b1, 23'h000301, 2'b01, 16'h0022);
        wr(24'h000600, 8'h11, 1'b1, 2);
        wr(24'h000603, 8'h22, 1'b1, -1);
        end_cycle();

        // sel=0 write, then read of a word with a pending byte
        wr(24'h000700, 8'h77, 1'b0, 2);
        exp_mem(1'b0, 23'h000080, 2'b11, 16'h0);
        rd(24'h000100, 8'h12, 0);
        wr(24'h000101, 8'h99, 1'b1, 2);
        exp_mem(1'b1, 23'h000080, 2'b01, 16'h0099);
        exp_mem(1'b0, 23'h000080, 2'b11, 16'h0);
        rd(24'h000100, 8'h12, 0);
        rd(24'h000101, 8'h99, 2);
        end_cycle();

        repeat (20) @(posedge clk);
        #1;
        chk("wb_queue_empty", 32'(wq.size()), 0);
        chk("mem_queue_empty", 32'(mq.size()), 0);
        chk("end_tmo", 32'(tmo), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
